// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between CPU and loader ports ahead of the
// data-memory aligner; rejects illegal accesses before they reach memory.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter logic [31:0] DMEM_SIZE = 32'd32768
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [1:0]  wstat0,
  input  logic [1:0]  rstat0,
  input  logic        signed0,
  output logic        done0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [1:0]  wstat1,
  input  logic [1:0]  rstat1,
  input  logic        signed1,
  output logic        done1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wstat,
  output logic [1:0]  mem_rstat,
  output logic        mem_signed,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [1:0]  mwstat_q, mwstat_d;
  logic [1:0]  mrstat_q, mrstat_d;
  logic        msgn_q, msgn_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        elig0, elig1, any, pick, bad;
  logic [31:0] s_addr, s_wdata, s_off;
  logic [1:0]  s_wstat, s_rstat, s_sz;
  logic        s_sgn;
  logic [31:0] rd;

  // A port still showing done is masked so a held req is not re-served.
  assign elig0 = req0 & ~done0_q;
  assign elig1 = req1 & ~done1_q;
  assign any   = elig0 | elig1;
  assign pick  = (elig0 & elig1) ? ~last_q : elig1;

  always_comb begin
    s_addr  = pick ? addr1   : addr0;
    s_wdata = pick ? wdata1  : wdata0;
    s_wstat = pick ? wstat1  : wstat0;
    s_rstat = pick ? rstat1  : rstat0;
    s_sgn   = pick ? signed1 : signed0;
    s_sz    = s_wstat | s_rstat;
    // Wrapping subtract makes below-base addresses fail too.
    s_off   = s_addr - DMEM_BASE;
    bad     = ((s_wstat != 2'b00) && (s_rstat != 2'b00))
            || ((s_wstat == 2'b00) && (s_rstat == 2'b00))
            || ((s_sz == 2'b10) && s_addr[0])
            || ((s_sz == 2'b11) && (s_addr[1:0] != 2'b00))
            || (s_off >= DMEM_SIZE);
  end

  assign rd = (mrstat_q != 2'b00) ? mem_rdata : 32'h0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstat_d = mwstat_q;
    mrstat_d = mrstat_q;
    msgn_d   = msgn_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = err0_q;
    err1_d   = err1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (any && !bad) begin
          maddr_d  = s_addr;
          mwdata_d = s_wdata;
          mwstat_d = s_wstat;
          mrstat_d = s_rstat;
          msgn_d   = s_sgn;
          gnt_d    = pick;
          state_d  = ACCESS;
        end else if (any) begin
          last_d = pick;
          if (pick) begin
            done1_d  = 1'b1;
            err1_d   = 1'b1;
            rdata1_d = 32'h0;
          end else begin
            done0_d  = 1'b1;
            err0_d   = 1'b1;
            rdata0_d = 32'h0;
          end
        end
      end
      ACCESS: begin
        if (gnt_q) begin
          done1_d  = 1'b1;
          err1_d   = 1'b0;
          rdata1_d = rd;
        end else begin
          done0_d  = 1'b1;
          err0_d   = 1'b0;
          rdata0_d = rd;
        end
        mwstat_d = 2'b00;
        mrstat_d = 2'b00;
        last_d   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      mwstat_q <= 2'b00;
      mrstat_q <= 2'b00;
      msgn_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstat_q <= mwstat_d;
      mrstat_q <= mrstat_d;
      msgn_q   <= msgn_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign mem_wstat  = mwstat_q;
  assign mem_rstat  = mrstat_q;
  assign mem_signed = msgn_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural aligner/memory plus a
// request-level reference model, directed and randomized traffic.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [31:0] SIZE = 32'd32768;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 0, req1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic [1:0]  wstat0 = 0, wstat1 = 0;
  logic [1:0]  rstat0 = 0, rstat1 = 0;
  logic        signed0 = 0, signed1 = 0;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wstat, mem_rstat;
  logic        mem_signed;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;

  logic [7:0] amem [64];
  logic [7:0] rmem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0),
    .wstat0(wstat0), .rstat0(rstat0), .signed0(signed0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1),
    .wstat1(wstat1), .rstat1(rstat1), .signed1(signed1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstat(mem_wstat), .mem_rstat(mem_rstat),
    .mem_signed(mem_signed), .mem_rdata(mem_rdata)
  );

  // Little-endian byte-lane aligner standing in for the real one.
  always_comb begin
    logic [5:0] i;
    logic [7:0] b0, b1, b2, b3;
    i  = mem_addr[5:0];
    b0 = amem[i];
    b1 = amem[6'(i + 6'd1)];
    b2 = amem[6'(i + 6'd2)];
    b3 = amem[6'(i + 6'd3)];
    mem_rdata = 32'h0;
    case (mem_rstat)
      2'b01: mem_rdata = {{24{mem_signed & b0[7]}}, b0};
      2'b10: mem_rdata = {{16{mem_signed & b1[7]}}, b1, b0};
      2'b11: mem_rdata = {b3, b2, b1, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wstat != 2'b00) begin
      amem[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_wstat[1]) amem[6'(mem_addr[5:0] + 6'd1)] <= mem_wdata[15:8];
      if (mem_wstat == 2'b11) begin
        amem[6'(mem_addr[5:0] + 6'd2)] <= mem_wdata[23:16];
        amem[6'(mem_addr[5:0] + 6'd3)] <= mem_wdata[31:24];
      end
    end
    if (reset_n && (mem_wstat != 2'b00 || mem_rstat != 2'b00))
      acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a,
                               input logic [1:0] ws, input logic [1:0] rs);
    int bytes;
    if ((ws == 0) == (rs == 0)) return 0;
    bytes = (ws != 0) ? (1 << (ws - 1)) : (1 << (rs - 1));
    if (bytes == 3) bytes = 4;
    if (a % bytes != 0) return 0;
    if (a < BASE || a >= BASE + SIZE) return 0;
    return 1;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : (s == 2'b11) ? 4 : 0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a,
                                         input logic [1:0] rs,
                                         input logic sg);
    longint v = 0;
    int n = nbytes(rs);
    int o = int'(a - BASE);
    for (int k = 0; k < n; k++) v += longint'(rmem[(o + k) % 64]) << (8 * k);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] ws);
    int o = int'(a - BASE);
    for (int k = 0; k < nbytes(ws); k++) rmem[(o + k) % 64] = d[8*k +: 8];
  endtask

  task automatic drv(input int p, input logic r, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] ws,
                     input logic [1:0] rs, input logic sg);
    if (p == 0) begin
      req0 = r; addr0 = a; wdata0 = wd;
      wstat0 = ws; rstat0 = rs; signed0 = sg;
    end else begin
      req1 = r; addr1 = a; wdata1 = wd;
      wstat1 = ws; rstat1 = rs; signed1 = sg;
    end
  endtask

  task automatic do_req(input int p, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] ws,
                        input logic [1:0] rs, input logic sg,
                        input bit hold, input int lat,
                        output logic [31:0] got);
    int cnt = 0;
    bit ok;
    logic [31:0] exp_rd;
    @(negedge clk);
    drv(p, 1'b1, a, wd, ws, rs, sg);
    forever begin
      @(posedge clk); #1;
      cnt++;
      if ((p == 0) ? done0 : done1) break;
      if (cnt > 30) begin
        chk("timeout", 32'(cnt), 32'd0);
        break;
      end
    end
    ok = legal(a, ws, rs);
    exp_rd = (ok && rs != 0) ? ref_rd(a, rs, sg) : 32'h0;
    got = (p == 0) ? rdata0 : rdata1;
    chk("err", {31'b0, (p == 0) ? err0 : err1}, {31'b0, !ok});
    chk("rdata", got, exp_rd);
    if (ok && ws != 0) ref_wr(a, wd, ws);
    if (lat >= 0) chk("latency", 32'(cnt), 32'(lat));
    if (!hold) drv(p, 1'b0, a, wd, ws, rs, sg);
    @(posedge clk); #1;
    chk("pulse", {31'b0, (p == 0) ? done0 : done1}, 32'd0);
    if (hold) drv(p, 1'b0, a, wd, ws, rs, sg);
  endtask

  task automatic rand_port(input int p);
    logic [31:0] a, wd, g;
    logic [1:0] ws, rs, sz;
    logic sg;
    int kind, off;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kind = $urandom_range(0, 9);
      off = $urandom_range(0, 7) * 4 + p * 32;
      sz = 2'($urandom_range(1, 3));
      if (sz == 2'b01) off += $urandom_range(0, 3);
      if (sz == 2'b10) off += 2 * $urandom_range(0, 1);
      a = BASE + 32'(off);
      wd = $urandom;
      sg = 1'($urandom_range(0, 1));
      ws = $urandom_range(0, 1) ? sz : 2'b00;
      rs = (ws != 0) ? 2'b00 : sz;
      case (kind)
        0: begin
          sz = 2'($urandom_range(2, 3));
          a = BASE + 32'(p * 32 + 1);
          rs = sz; ws = 2'b00;
        end
        1: a = $urandom_range(0, 1) ? BASE - 32'd4 : BASE + SIZE;
        2: begin ws = sz; rs = sz; end
        3: begin ws = 2'b00; rs = 2'b00; end
        default: ;
      endcase
      do_req(p, a, wd, ws, rs, sg, 0, -1, g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    int a0, got, ep, pp;
    for (int i = 0; i < 64; i++) begin
      amem[i] = 8'($urandom);
      rmem[i] = amem[i];
    end
    #1;
    chk("rst_done0", {31'b0, done0}, 0);
    chk("rst_done1", {31'b0, done1}, 0);
    chk("rst_err", {30'b0, err0, err1}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mstat", {28'b0, mem_wstat, mem_rstat}, 0);

    // Abort a store mid-ACCESS.
    @(negedge clk);
    reset_n = 1'b1;
    drv(0, 1'b1, BASE + 32'h8, 32'h1234_5678, 2'b11, 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("acc_wstat", {30'b0, mem_wstat}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("midrst_wstat", {30'b0, mem_wstat}, 0);
    chk("midrst_rstat", {30'b0, mem_rstat}, 0);
    chk("midrst_done0", {31'b0, done0}, 0);
    chk("midrst_rdata0", rdata0, 0);
    drv(0, 1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Contention right after release: port 0 wins, then strict alternation.
    @(negedge clk);
    reset_n = 1'b1;
    drv(0, 1'b1, BASE, 0, 2'b00, 2'b11, 1'b0);
    drv(1, 1'b1, BASE + 32'd32, 0, 2'b00, 2'b11, 1'b0);
    got = 0; ep = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done0 && done1) chk("both_done", 1, 0);
      else if (done0 || done1) begin
        pp = done1 ? 1 : 0;
        chk("rr_order", 32'(pp), 32'(ep));
        chk("rr_rdata", pp ? rdata1 : rdata0,
            ref_rd(pp ? BASE + 32'd32 : BASE, 2'b11, 1'b0));
        ep ^= 1;
        got++;
      end
    end
    chk("rr_count", 32'(got), 32'd8);
    drv(0, 1'b0, 0, 0, 0, 0, 0);
    drv(1, 1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    do_req(0, BASE + 32'h10, 32'hDEAD_BEEF, 2'b11, 2'b00, 0, 0, 2, g);
    do_req(0, BASE + 32'h10, 0, 2'b00, 2'b11, 0, 0, 2, g);
    chk("ld_word", g, 32'hDEAD_BEEF);

    do_req(1, BASE + 32'h21, 32'h0000_0080, 2'b01, 2'b00, 0, 0, 2, g);
    do_req(1, BASE + 32'h21, 0, 2'b00, 2'b01, 1, 0, 2, g);
    chk("ld_sbyte", g, 32'hFFFF_FF80);
    do_req(1, BASE + 32'h21, 0, 2'b00, 2'b01, 0, 0, 2, g);
    chk("ld_ubyte", g, 32'h0000_0080);

    a0 = acc_cnt;
    do_req(0, BASE + 32'h1, 32'hFFFF, 2'b10, 2'b00, 0, 0, 1, g);
    do_req(1, 32'h0, 0, 2'b00, 2'b11, 0, 0, 1, g);
    do_req(0, BASE + 32'h4, 0, 2'b11, 2'b11, 0, 0, 1, g);
    chk("err_no_access", 32'(acc_cnt - a0), 0);

    a0 = acc_cnt;
    do_req(0, BASE + 32'h10, 0, 2'b00, 2'b11, 0, 1, 2, g);
    repeat (3) @(posedge clk);
    #1;
    chk("mask_one_access", 32'(acc_cnt - a0), 1);

    fork
      rand_port(0);
      rand_port(1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
